// File: rtl/fv_stim_driver.sv
// Stimulus/check side of the o1/o2 equivalence harness: drives LFSR vectors on
// a..h, compares the returned o1/o2 pair after LAT cycles, records the first miss.
module fv_stim_driver #(
  parameter int N_VEC = 256,
  parameter int CNT_W = 16,
  parameter int LAT   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       seed_i,
  output logic [7:0]       stim_o,
  input  logic             o1_i,
  input  logic             o2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] fail_idx_o,
  output logic [CNT_W-1:0] vec_cnt_o
);

  localparam int IW = CNT_W + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_VEC - 1);
  localparam logic [IW-1:0] CNT_MAX  = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  lfsr_q, lfsr_d;
  logic [7:0]                  stim_q, stim_d;
  logic [IW-1:0]               cnt_q, cnt_d;
  logic [2:0]                  drain_q, drain_d;
  logic [LAT-1:0]              tag_vld_q, tag_vld_d;
  logic [LAT-1:0][CNT_W-1:0]   tag_idx_q, tag_idx_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        fail_q, fail_d;
  logic [CNT_W-1:0]            fail_idx_q, fail_idx_d;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    stim_d     = stim_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;

    // Tag pipeline mirrors the CUT latency; the oldest tag selects what gets compared.
    for (int i = LAT - 1; i > 0; i--) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    tag_vld_d[0] = 1'b0;
    tag_idx_d[0] = '0;

    if (tag_vld_q[LAT-1] && (o1_i != o2_i) && !fail_q) begin
      fail_d     = 1'b1;
      fail_idx_d = tag_idx_q[LAT-1];
    end

    case (state_q)
      IDLE, DONE: begin
        // Placed after the compare so a new campaign overrides any late result.
        if (start_i) begin
          state_d    = RUN;
          lfsr_d     = (seed_i == 8'h00) ? 8'h01 : seed_i;
          cnt_d      = '0;
          fail_d     = 1'b0;
          fail_idx_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      RUN: begin
        stim_d       = lfsr_q;
        lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        cnt_d        = cnt_q + 1'b1;
        tag_vld_d[0] = 1'b1;
        tag_idx_d[0] = cnt_q[CNT_W-1:0];
        if (cnt_q == LAST_IDX) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == 3'(LAT - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      lfsr_q     <= 8'h01;
      stim_q     <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      stim_q     <= stim_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign stim_o     = stim_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign fail_idx_o = fail_idx_q;
  // A full 2**CNT_W campaign cannot be shown in CNT_W bits; it reads as all-ones.
  assign vec_cnt_o  = (cnt_q > CNT_MAX) ? {CNT_W{1'b1}} : cnt_q[CNT_W-1:0];

endmodule

// File: tb/tb_fv_stim_driver.sv
// Directed bench for fv_stim_driver with a 16-vector campaign and a two-cycle CUT model.
module tb_fv_stim_driver;

  localparam int N_VEC = 16;
  localparam int CNT_W = 8;
  localparam int LAT   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       seed;
  logic [7:0]       stim;
  logic             o1, o2;
  logic             busy, done, fail;
  logic [CNT_W-1:0] fail_idx, vec_cnt;

  logic [7:0]       stim_d;
  logic             flip_en;
  logic [7:0]       flip_a, flip_b;
  logic [7:0]       v [N_VEC];

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  fv_stim_driver #(.N_VEC(N_VEC), .CNT_W(CNT_W), .LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .seed_i(seed),
    .stim_o(stim), .o1_i(o1), .o2_i(o2), .busy_o(busy), .done_o(done),
    .fail_o(fail), .fail_idx_o(fail_idx), .vec_cnt_o(vec_cnt)
  );

  // CUT model: one register stage plus the sampling register gives LAT=2.
  always @(posedge clk) stim_d <= stim;
  assign o1 = ^stim_d;
  assign o2 = o1 ^ (flip_en && (stim_d == flip_a || stim_d == flip_b));

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge right after the start edge.
  task automatic start_run(input logic [7:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int cyc);
    cyc = n0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = 8'h00;
    flip_en = 1'b0; flip_a = 8'h00; flip_b = 8'h00;
    v[0] = 8'h01;
    for (int i = 1; i < N_VEC; i++) v[i] = lfsr_next(v[i-1]);

    #1;
    check("rst_outputs", {stim, busy, done, fail, fail_idx, vec_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Seed 1, matching CUT: full stream, nominal completion time.
    start_run(8'h01);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      check($sformatf("t1_stim%0d", i), 32'(stim), 32'(v[i]));
    end
    wait_done(N_VEC, n);
    check("t1_done_cycles", 32'(n), 32'(N_VEC + LAT));
    check("t1_fail", 32'(fail), 32'd0);
    check("t1_vec_cnt", 32'(vec_cnt), 32'(N_VEC));
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_stim_hold", 32'(stim), 32'(v[N_VEC-1]));

    // Seed 0 behaves as seed 1.
    start_run(8'h00);
    @(negedge clk); check("t2_v0", 32'(stim), 32'h01);
    @(negedge clk); check("t2_v1", 32'(stim), 32'hB8);
    @(negedge clk); check("t2_v2", 32'(stim), 32'h5C);
    @(negedge clk); check("t2_v3", 32'(stim), 32'h2E);
    wait_done(4, n);
    check("t2_done_cycles", 32'(n), 32'(N_VEC + LAT));

    // Mismatches on vectors 5 and 9, plus a start pulse during RUN.
    flip_a = v[5]; flip_b = v[9]; flip_en = 1'b1;
    start_run(8'h01);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_cnt_after_pulse", 32'(vec_cnt), 32'd5);
    check("t5_busy", 32'(busy), 32'd1);
    wait_done(5, n);
    check("t3_done_cycles", 32'(n), 32'(N_VEC + LAT));
    check("t3_fail", 32'(fail), 32'd1);
    check("t3_fail_idx", 32'(fail_idx), 32'd5);

    // Restart from DONE clears the previous failure.
    flip_en = 1'b0;
    start_run(8'h01);
    check("t5_fail_cleared", 32'(fail), 32'd0);
    check("t5_done_dropped", 32'(done), 32'd0);
    check("t5_cnt_cleared", 32'(vec_cnt), 32'd0);
    wait_done(0, n);
    check("t5_done_cycles", 32'(n), 32'(N_VEC + LAT));
    check("t5_fail", 32'(fail), 32'd0);

    // Mismatch only on the final vector is caught while draining.
    flip_a = v[N_VEC-1]; flip_b = v[N_VEC-1]; flip_en = 1'b1;
    start_run(8'h01);
    wait_done(0, n);
    check("t6_done_cycles", 32'(n), 32'(N_VEC + LAT));
    check("t6_fail", 32'(fail), 32'd1);
    check("t6_fail_idx", 32'(fail_idx), 32'(N_VEC - 1));

    // Asynchronous reset mid-campaign, then a clean replay.
    flip_en = 1'b0;
    start_run(8'h01);
    repeat (10) @(negedge clk);
    check("t4_cnt_before_rst", 32'(vec_cnt), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_outputs", {stim, busy, done, fail, fail_idx, vec_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(8'h01);
    @(negedge clk); check("t4_replay_v0", 32'(stim), 32'h01);
    @(negedge clk); check("t4_replay_v1", 32'(stim), 32'hB8);
    check("t4_replay_cnt", 32'(vec_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
